// File: rtl/param_updown_counter_if.sv
// Control inputs and count/flag outputs of param_updown_counter bundled as one port.
// master drives the controls and observes the count; slave is the counter itself.
interface param_updown_counter_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, load, load_val,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Purpose: up/down counter over 0..MAX_VAL with load, prescaled enable, wrap/saturate and flags.
// Latency: count/wrap/ovf update on the step edge; tc is combinational from count and up.
// Backpressure: none; every enabled edge is consumed immediately.
module param_updown_counter #(
    parameter int WIDTH    = 6,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input logic                    clk,
    input logic                    reset,
    param_updown_counter_if.slave  bus
);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
    localparam logic [PW-1:0]    PSC_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    psc_q, psc_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             tc;

    assign tc = (bus.up && (count_q == MAX_C)) || (!bus.up && (count_q == '0));

    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (bus.load) begin
            count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
            psc_d   = '0;
            ovf_d   = 1'b0;
        end else if (bus.en) begin
            if (psc_q == PSC_LAST) begin
                psc_d = '0;
                // A step at the terminal count is the boundary event, whether it wraps or holds.
                if (tc) begin
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                    if (SATURATE == 0) begin
                        count_d = bus.up ? '0 : MAX_C;
                    end
                end else begin
                    count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
                end
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            psc_q   <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// Three counter configurations driven with identical stimulus; a queue-based scoreboard
// compares each against an integer reference model of the counting rules.
module tb_param_updown_counter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(6)) if_a ();
    param_updown_counter_if #(.WIDTH(6)) if_b ();
    param_updown_counter_if #(.WIDTH(6)) if_c ();

    param_updown_counter #(.WIDTH(6), .MAX_VAL(63), .SATURATE(0), .PRESCALE(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    param_updown_counter #(.WIDTH(6), .MAX_VAL(20), .SATURATE(1), .PRESCALE(4))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    param_updown_counter #(.WIDTH(6), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    localparam int MAXV [3] = '{63, 20, 9};
    localparam int SATV [3] = '{0, 1, 1};
    localparam int PREV [3] = '{1, 4, 1};

    typedef struct {
        int cnt;
        bit wrap;
        bit ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int m_cnt [3];
    int m_ph  [3];
    bit m_ovf [3];

    logic [5:0] cnt_o  [3];
    logic       tc_o   [3];
    logic       wrap_o [3];
    logic       ovf_o  [3];
    logic       en_r, up_r, load_r;
    logic [5:0] lv_r;

    assign if_a.en = en_r;  assign if_a.up = up_r;  assign if_a.load = load_r;  assign if_a.load_val = lv_r;
    assign if_b.en = en_r;  assign if_b.up = up_r;  assign if_b.load = load_r;  assign if_b.load_val = lv_r;
    assign if_c.en = en_r;  assign if_c.up = up_r;  assign if_c.load = load_r;  assign if_c.load_val = lv_r;
    assign cnt_o[0] = if_a.count; assign tc_o[0] = if_a.tc; assign wrap_o[0] = if_a.wrap; assign ovf_o[0] = if_a.ovf;
    assign cnt_o[1] = if_b.count; assign tc_o[1] = if_b.tc; assign wrap_o[1] = if_b.wrap; assign ovf_o[1] = if_b.ovf;
    assign cnt_o[2] = if_c.count; assign tc_o[2] = if_c.tc; assign wrap_o[2] = if_c.wrap; assign ovf_o[2] = if_c.ovf;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, idx, $time, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the counting rules.
    function automatic exp_t model(input int i, input bit r, input bit e, input bit u,
                                   input bit l, input int lv);
        exp_t x;
        x.wrap = 1'b0;
        if (r) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_ovf[i] = 1'b0;
        end else if (l) begin
            m_cnt[i] = (lv > MAXV[i]) ? MAXV[i] : lv;
            m_ph[i]  = 0;
            m_ovf[i] = 1'b0;
        end else if (e) begin
            m_ph[i] = m_ph[i] + 1;
            if (m_ph[i] == PREV[i]) begin
                m_ph[i] = 0;
                if ((u && m_cnt[i] == MAXV[i]) || (!u && m_cnt[i] == 0)) begin
                    x.wrap   = 1'b1;
                    m_ovf[i] = 1'b1;
                    if (SATV[i] == 0) m_cnt[i] = u ? 0 : MAXV[i];
                end else begin
                    m_cnt[i] = u ? m_cnt[i] + 1 : m_cnt[i] - 1;
                end
            end
        end
        x.cnt = m_cnt[i];
        x.ovf = m_ovf[i];
        return x;
    endfunction

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lv);
        @(negedge clk);
        reset  = r;
        en_r   = e;
        up_r   = u;
        load_r = l;
        lv_r   = 6'(lv);
        q0.push_back(model(0, r, e, u, l, lv));
        q1.push_back(model(1, r, e, u, l, lv));
        q2.push_back(model(2, r, e, u, l, lv));
    endtask

    task automatic check_one(input int i, input exp_t x);
        int exp_tc;
        exp_tc = ((up_r && x.cnt == MAXV[i]) || (!up_r && x.cnt == 0)) ? 1 : 0;
        chk("count", i, int'(cnt_o[i]), x.cnt);
        chk("wrap",  i, int'(wrap_o[i]), int'(x.wrap));
        chk("ovf",   i, int'(ovf_o[i]), int'(x.ovf));
        chk("tc",    i, int'(tc_o[i]), exp_tc);
    endtask

    // Monitor: each edge the DUTs present a new registered state; pop and compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) check_one(0, q0.pop_front());
            if (q1.size() > 0) check_one(1, q1.pop_front());
            if (q2.size() > 0) check_one(2, q2.pop_front());
        end
    end

    initial begin
        reset = 1'b1; en_r = 1'b0; up_r = 1'b1; load_r = 1'b0; lv_r = '0;
        drive(1, 0, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        // Full up sweep through the wrap point.
        for (int k = 0; k < 66; k++) drive(0, 1, 1, 0, 0);
        // Down wrap from 2.
        drive(0, 1, 1, 1, 2);
        for (int k = 0; k < 5; k++) drive(0, 1, 0, 0, 0);
        // Priority: reset over load, load over step, clamping.
        drive(1, 1, 1, 1, 40);
        drive(0, 0, 1, 1, 63);
        drive(0, 1, 1, 1, 17);
        drive(0, 0, 1, 1, 50);
        drive(0, 1, 1, 0, 0);
        // Prescale with an enable gap mid-phase.
        drive(0, 0, 1, 1, 0);
        for (int k = 0; k < 6; k++) drive(0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 0);
        for (int k = 0; k < 10; k++) drive(0, 1, 1, 0, 0);
        // Saturation hold repeatedly at the top.
        for (int k = 0; k < 50; k++) drive(0, 1, 1, 0, 0);
        // Reset mid-operation with prescaler phase nonzero.
        drive(0, 0, 1, 1, 37);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        for (int k = 0; k < 9; k++) drive(0, 1, 1, 0, 0);
        // Direction change mid-prescale.
        for (int k = 0; k < 6; k++) drive(0, 1, 0, 0, 0);
        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 15) == 0), int'($urandom_range(0, 63)));
        end
        repeat (3) @(posedge clk);
        #2;
        chk("drain", 0, q0.size() + q1.size() + q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
